empaquetador_2a8: RTL and testbench
===================================

EMPAQUETADOR_2A8 -- requirements
Module: empaquetador_2a8

Interface
REQ-001 Parameter LSB_FIRST, default 1: 1 = first accepted symbol lands in data_out[1:0]; 0 = first symbol lands in data_out[7:6].
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset_L  input  1  reset; asynchronous, active-low.
REQ-004 data_in  input  2  symbol from upstream mux/flop stage.
REQ-005 valid_in  input  1  data_in holds a symbol to transfer this cycle.
REQ-006 ready_out  output  1  block accepts data_in this cycle.
REQ-007 data_out  output  8  packed word of four symbols.
REQ-008 valid_out  output  1  data_out holds a complete word.
REQ-009 ready_in  input  1  downstream accepts data_out this cycle.
REQ-010 sym_count  output  2  symbols currently held in the accumulator (0..3).
REQ-011 drop_err  output  1  sticky flag: a symbol was offered while ready_out=0.

Function
REQ-012 Input transfer occurs on a posedge when valid_in=1 and ready_out=1; output transfer occurs on a posedge when valid_out=1 and ready_in=1.
REQ-013 Each input transfer shall write data_in into accumulator slot sym_count and increment sym_count, modulo 4.
REQ-014 The transfer that takes sym_count from 3 to 0 shall load the three held symbols plus data_in into data_out and set valid_out=1, all at that same posedge; a word therefore appears one cycle after its 4th symbol is presented.
REQ-015 Output FSM: EMPTY (valid_out=0) and FULL (valid_out=1).
- EMPTY->FULL on word completion.
- FULL->EMPTY on output transfer without completion.
- FULL->FULL, with data_out replaced, when an output transfer and a completion occur on the same posedge.
REQ-016 ready_out shall be combinational and shall equal 0 only when sym_count=3, valid_out=1 and ready_in=0; otherwise 1.
REQ-017 Symbols 0..2 of a word shall be accepted while FULL regardless of ready_in; the accumulator never stalls except per REQ-016.
REQ-018 data_out shall remain stable while valid_out=1 and ready_in=0.
REQ-019 valid_in=1 with ready_out=0 shall set drop_err; that symbol shall not be stored and sym_count shall not change.
REQ-020 drop_err shall clear only on reset.
REQ-021 valid_in=0 cycles shall not alter accumulator or sym_count; gaps between symbols of a word are allowed.
REQ-022 Bit mapping: with LSB_FIRST=1, symbol k (k=0..3 in arrival order) maps to data_out[2k+1:2k]; with LSB_FIRST=0 it maps to data_out[7-2k:6-2k].

Reset
REQ-023 While reset_L=0: sym_count=0, accumulator=0, data_out=8'h00, valid_out=0, drop_err=0, ready_out=1.
REQ-024 Reset asserted mid-word shall discard the partial word; a held unconsumed word shall also be discarded.
REQ-025 The first posedge after reset_L rises shall accept a symbol normally.

Structure
REQ-026 A shared include file shall define the symbol width (2), word width (8), symbols per word (4) and the EMPTY/FULL state encodings.
REQ-027 One sub-module, etapa_salida, shall hold the output register, valid_out and the EMPTY/FULL FSM.
REQ-028 The accumulator, sym_count and drop_err logic shall stay in empaquetador_2a8.

Verification
REQ-029 LSB_FIRST=1, ready_in=1, symbols 11,00,10,01 on consecutive cycles -> data_out=8'h63 with valid_out=1 for exactly one cycle, the cycle after the 4th symbol.
REQ-030 Same stimulus with LSB_FIRST=0 -> data_out=8'hC9.
REQ-031 ready_in=0, eight symbols 11,11,11,11,01,01,01,01 offered back-to-back:
- ready_out=0 once sym_count=3 of the second word; data_out holds 8'hFF.
- drop_err=1 if valid_in stays high through the stall.
- Raising ready_in yields 8'h55 one cycle after the 4th 01 is accepted.
REQ-032 ready_in=1, sym_count=3, FULL, 4th symbol presented -> same-posedge drain and reload; valid_out stays 1 with the new word, and ready_out stays 1 throughout.
REQ-033 Assert reset_L=0 after two symbols -> sym_count=0 and valid_out=0 immediately.
- After release, four symbols 01,01,01,01 -> data_out=8'h55; no residue from the old symbols.
REQ-034 Symbols with valid_in=0 gaps of 1-3 cycles between them -> same word as gap-free input; drop_err stays 0.

Source files
------------

// File: rtl/empaquetador_2a8_pkg.sv
// Shared widths, output-stage state encoding and word-packing helper for the
// 2-bit to 8-bit symbol packer.
package empaquetador_2a8_pkg;

  localparam int SYM_W         = 2;
  localparam int WORD_W        = 8;
  localparam int SYMS_PER_WORD = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } estado_t;

  // s0 is the first symbol received and s3 the last.
  function automatic logic [WORD_W-1:0] pack_word(
    input bit               lsb_first,
    input logic [SYM_W-1:0] s0,
    input logic [SYM_W-1:0] s1,
    input logic [SYM_W-1:0] s2,
    input logic [SYM_W-1:0] s3
  );
    if (lsb_first) pack_word = {s3, s2, s1, s0};
    else           pack_word = {s0, s1, s2, s3};
  endfunction

endpackage

// File: rtl/empaquetador_2a8_etapa_salida.sv
// Output stage: holds the packed word and valid_out until downstream takes it.
// A new word can replace the old one on the same edge that drains it.
module etapa_salida
  import empaquetador_2a8_pkg::*;
(
  input  logic              clk,
  input  logic              reset_L,
  input  logic              load,
  input  logic [WORD_W-1:0] word_in,
  input  logic              ready_in,
  output logic [WORD_W-1:0] data_out,
  output logic              valid_out
);

  estado_t state, state_next;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state    <= EMPTY;
      data_out <= '0;
    end else begin
      state <= state_next;
      if (load) data_out <= word_in;
    end
  end

  // The packer never raises load while FULL and stalled, so load always wins.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (load) state_next = FULL;
      FULL: begin
        if (load)          state_next = FULL;
        else if (ready_in) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  assign valid_out = (state == FULL);

endmodule

// File: rtl/empaquetador_2a8.sv
// Packs four 2-bit symbols into one 8-bit word with valid/ready on both sides.
// Only a fourth symbol arriving while a finished word is blocked has to wait.
module empaquetador_2a8
  import empaquetador_2a8_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [SYM_W-1:0]  data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [WORD_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [1:0]        sym_count,
  output logic              drop_err
);

  logic [2:0][SYM_W-1:0] acc;
  logic                  in_xfer;
  logic                  complete;
  logic [WORD_W-1:0]     word_next;

  assign ready_out = !((sym_count == 2'd3) && valid_out && !ready_in);
  assign in_xfer   = valid_in && ready_out;
  assign complete  = in_xfer && (sym_count == 2'd3);
  assign word_next = pack_word(LSB_FIRST, acc[0], acc[1], acc[2], data_in);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      acc       <= '0;
      sym_count <= 2'd0;
      drop_err  <= 1'b0;
    end else begin
      if (in_xfer) begin
        case (sym_count)
          2'd0:    acc[0] <= data_in;
          2'd1:    acc[1] <= data_in;
          2'd2:    acc[2] <= data_in;
          default: ;
        endcase
        sym_count <= sym_count + 2'd1;
      end
      if (valid_in && !ready_out) drop_err <= 1'b1;
    end
  end

  etapa_salida u_salida (
    .clk       (clk),
    .reset_L   (reset_L),
    .load      (complete),
    .word_in   (word_next),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

endmodule

// File: tb/tb_empaquetador_2a8.sv
// Scoreboard bench: two packers (LSB-first and MSB-first) share one stimulus;
// expected words are queued on issue and popped by negedge monitors.
module tb_empaquetador_2a8;

  logic       clk = 1'b0;
  logic       reset_L;
  logic [1:0] data_in;
  logic       valid_in;
  logic       ready_in;

  logic       ready_out, valid_out, drop_err;
  logic [7:0] data_out;
  logic [1:0] sym_count;
  logic       ready_out_m, valid_out_m, drop_err_m;
  logic [7:0] data_out_m;
  logic [1:0] sym_count_m;

  int checks = 0;
  int fails  = 0;
  logic [7:0] expLsb[$];
  logic [7:0] expMsb[$];

  always #5 clk = ~clk;

  empaquetador_2a8 #(.LSB_FIRST(1'b1)) dut (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in), .sym_count(sym_count), .drop_err(drop_err)
  );

  empaquetador_2a8 #(.LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out_m), .data_out(data_out_m), .valid_out(valid_out_m),
    .ready_in(ready_in), .sym_count(sym_count_m), .drop_err(drop_err_m)
  );

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One symbol per call; valid_in drops only if the next call does not re-raise it.
  task automatic applyStimulus(input logic [1:0] s);
    data_in  = s;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_L && valid_out && ready_in) begin
      if (expLsb.size() == 0) checkOutput("lsb_unexpected_word", data_out, 8'hxx);
      else                    checkOutput("lsb_word", data_out, expLsb.pop_front());
    end
    if (reset_L && valid_out_m && ready_in) begin
      if (expMsb.size() == 0) checkOutput("msb_unexpected_word", data_out_m, 8'hxx);
      else                    checkOutput("msb_word", data_out_m, expMsb.pop_front());
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_L  = 1'b0;
    data_in  = 2'b00;
    valid_in = 1'b0;
    ready_in = 1'b1;
    #12;
    checkOutput("reset_sym_count", {6'd0, sym_count}, 8'd0);
    checkOutput("reset_data_out", data_out, 8'h00);
    checkOutput("reset_valid_out", {7'd0, valid_out}, 8'd0);
    checkOutput("reset_drop_err", {7'd0, drop_err}, 8'd0);
    checkOutput("reset_ready_out", {7'd0, ready_out}, 8'd1);
    checkOutput("reset_valid_out_m", {7'd0, valid_out_m}, 8'd0);
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk);
    #1;

    // Basic word, both bit orders, valid_out exactly one cycle.
    expLsb.push_back(8'h63);
    expMsb.push_back(8'hC9);
    applyStimulus(2'b11);
    checkOutput("first_symbol_accepted", {6'd0, sym_count}, 8'd1);
    applyStimulus(2'b00);
    applyStimulus(2'b10);
    applyStimulus(2'b01);
    checkOutput("basic_valid_high", {7'd0, valid_out}, 8'd1);
    checkOutput("basic_data_lsb", data_out, 8'h63);
    checkOutput("basic_data_msb", data_out_m, 8'hC9);
    idle(1);
    checkOutput("basic_valid_one_cycle", {7'd0, valid_out}, 8'd0);
    checkOutput("basic_count_wrapped", {6'd0, sym_count}, 8'd0);
    idle(2);

    // Gaps between symbols do not change the word.
    expLsb.push_back(8'h8D);
    expMsb.push_back(8'h72);
    applyStimulus(2'b01);
    idle(1);
    applyStimulus(2'b11);
    idle(2);
    applyStimulus(2'b00);
    checkOutput("gap_count_held", {6'd0, sym_count}, 8'd3);
    idle(3);
    applyStimulus(2'b10);
    idle(2);
    checkOutput("gap_drop_err_clear", {7'd0, drop_err}, 8'd0);

    // Same-edge drain and reload while FULL.
    ready_in = 1'b0;
    expLsb.push_back(8'hAA);
    expMsb.push_back(8'hAA);
    expLsb.push_back(8'hE4);
    expMsb.push_back(8'h1B);
    repeat (4) applyStimulus(2'b10);
    applyStimulus(2'b00);
    applyStimulus(2'b01);
    applyStimulus(2'b10);
    checkOutput("reload_held_word", data_out, 8'hAA);
    ready_in = 1'b1;
    #1;
    checkOutput("reload_ready_out", {7'd0, ready_out}, 8'd1);
    applyStimulus(2'b11);
    checkOutput("reload_valid_kept", {7'd0, valid_out}, 8'd1);
    checkOutput("reload_new_lsb", data_out, 8'hE4);
    checkOutput("reload_new_msb", data_out_m, 8'h1B);
    idle(2);

    // Stall with ready_in low: fourth symbol of the second word is refused.
    ready_in = 1'b0;
    expLsb.push_back(8'hFF);
    expMsb.push_back(8'hFF);
    expLsb.push_back(8'h55);
    expMsb.push_back(8'h55);
    repeat (4) applyStimulus(2'b11);
    repeat (3) applyStimulus(2'b01);
    data_in  = 2'b01;
    valid_in = 1'b1;
    #1;
    checkOutput("stall_ready_out_low", {7'd0, ready_out}, 8'd0);
    idle(2);
    checkOutput("stall_drop_err", {7'd0, drop_err}, 8'd1);
    checkOutput("stall_count_frozen", {6'd0, sym_count}, 8'd3);
    checkOutput("stall_data_stable", data_out, 8'hFF);
    ready_in = 1'b1;
    #1;
    checkOutput("stall_release_ready", {7'd0, ready_out}, 8'd1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    checkOutput("stall_new_word", data_out, 8'h55);
    idle(2);
    checkOutput("drop_err_sticky", {7'd0, drop_err}, 8'd1);

    // Reset mid-word with a held word discards both.
    ready_in = 1'b0;
    repeat (4) applyStimulus(2'b10);
    applyStimulus(2'b11);
    applyStimulus(2'b11);
    checkOutput("pre_reset_count", {6'd0, sym_count}, 8'd2);
    reset_L = 1'b0;
    #1;
    checkOutput("midreset_count", {6'd0, sym_count}, 8'd0);
    checkOutput("midreset_valid", {7'd0, valid_out}, 8'd0);
    checkOutput("midreset_drop_err", {7'd0, drop_err}, 8'd0);
    @(negedge clk);
    reset_L  = 1'b1;
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    expLsb.push_back(8'h55);
    expMsb.push_back(8'h55);
    repeat (4) applyStimulus(2'b01);
    checkOutput("post_reset_word", data_out, 8'h55);
    idle(3);

    checkOutput("lsb_queue_drained", 8'(expLsb.size()), 8'd0);
    checkOutput("msb_queue_drained", 8'(expMsb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
